multicycle_controlunit: RTL and testbench

//  Multi-cycle RV32I control FSM; successor to the single-cycle decoder/control path.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_controlunit_alu_decoder.sv | 31 +++
 rtl/multicycle_controlunit.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_controlunit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JLINK, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // funct3 010/011 are not branches; the FSM traps on them before using this
    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controlunit_alu_decoder.sv
// ALU operation decode from funct3/funct7_5; subtraction only applies to R-type.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7_5,
    input  logic                 i_is_r,
    output logic [ALUCTRL_W-1:0] o_alu_ctrl
);

    logic [3:0] w_alu;

    always_comb begin
        w_alu = ALU_ADD;
        unique case (i_funct3)
            3'b000: w_alu = (i_is_r && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu = ALU_SLL;
            3'b010: w_alu = ALU_SLT;
            3'b011: w_alu = ALU_SLTU;
            3'b100: w_alu = ALU_XOR;
            3'b101: w_alu = i_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu = ALU_OR;
            3'b111: w_alu = ALU_AND;
        endcase
    end

    assign o_alu_ctrl = ALUCTRL_W'(w_alu);

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM over a shared memory with a ready handshake.
// Optional retired-instruction counter enabled by defining CTRL_PERF_EN.
module multicycle_controlunit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 Zero,
    input  logic                 LT,
    input  logic                 LTU,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 instr_done,
    output logic                 trap
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]     instret
`endif
);

    if (ALUCTRL_W < 4) begin : g_bad_aluctrl_w
        $error("ALUCTRL_W must be >= 4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    state_t                 r_state, w_next;
    logic [ALUCTRL_W-1:0]   w_alu_ctrl;
    logic                   w_timeout;

    alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .i_is_r     (r_state == S_EXECR),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // Wait counter only exists when a timeout bound is configured
    if (MEM_TIMEOUT > 0) begin : g_tmo
        localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
        logic [TW-1:0] r_wait_cnt;
        logic          w_mem_wait;

        assign w_mem_wait = !rst && !mem_ready &&
                            (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR);

        always_ff @(posedge clk) begin
            if (rst || !w_mem_wait) r_wait_cnt <= '0;
            else                    r_wait_cnt <= r_wait_cnt + 1'b1;
        end

        // Trapping as the count reaches the bound puts trap on the following cycle
        assign w_timeout = w_mem_wait && (r_wait_cnt == TW'(MEM_TIMEOUT - 1));
    end else begin : g_no_tmo
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ImmSrc     = IMM_I;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        instr_done = 1'b0;
        trap       = 1'b0;
        // While rst is high every output stays at its idle value
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ResultSrc = RES_ALURES;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_DECODE;
                    end else if (w_timeout) begin
                        w_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_B;
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXECR;
                        OP_ITYPE:          w_next = S_EXECI;
                        OP_BRANCH:         w_next = S_BRANCH;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_LUI:            w_next = S_LUI;
                        OP_AUIPC:          w_next = S_AUIPC;
                        default:           w_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                    w_next  = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    if (mem_ready)      w_next = S_MEMWB;
                    else if (w_timeout) w_next = S_TRAP;
                end
                S_MEMWB: begin
                    ResultSrc  = RES_RDATA;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end else if (w_timeout) begin
                        w_next = S_TRAP;
                    end
                end
                S_EXECR, S_EXECI: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = (r_state == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                    ALUControl = w_alu_ctrl;
                    w_next     = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUControl = ALUCTRL_W'(ALU_SUB);
                    if (funct3[2:1] == 2'b01) begin
                        w_next = S_TRAP;
                    end else begin
                        PCWrite    = branch_taken(funct3, Zero, LT, LTU);
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    PCWrite = 1'b1;
                    w_next  = S_ALUWB;
                end
                S_JALR: begin
                    ALUSrcA   = SRCA_RS1;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURES;
                    PCWrite   = 1'b1;
                    w_next    = S_JLINK;
                end
                S_JLINK: begin
                    ALUSrcA    = SRCA_OLDPC;
                    ResultSrc  = RES_ALURES;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_LUI, S_AUIPC: begin
                    ALUSrcA = (r_state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                    w_next  = S_ALUWB;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: w_next = S_TRAP;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst)             r_instret <= '0;
        else if (instr_done) r_instret <= r_instret + 1'b1;
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit: per-cycle expected outputs are queued
// by the stimulus and compared under a care mask by a negedge monitor.
module tb_multicycle_controlunit;

    localparam int D = -1;

    typedef struct packed {
        logic [20:0] v;
        logic [20:0] m;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       Zero = 1'b0, LT = 1'b0, LTU = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_ready2 = 1'b0;

    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    logic       mem_req2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, instr_done2, trap2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
    logic [2:0] ImmSrc2;
    logic [3:0] ALUControl2;
`ifdef CTRL_PERF_EN
    logic [31:0] instret, instret2;
`endif

    int   checks = 0;
    int   errors = 0;
    bit   t2_done = 1'b0;
    ent_t q[$];

    always #5 clk = ~clk;

    multicycle_controlunit #(.ALUCTRL_W(4), .MEM_TIMEOUT(0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .instr_done(instr_done), .trap(trap)
`ifdef CTRL_PERF_EN
        , .instret(instret)
`endif
    );

    multicycle_controlunit #(.ALUCTRL_W(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst2), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready2),
        .mem_req(mem_req2), .MemWrite(MemWrite2), .AdrSrc(AdrSrc2), .IRWrite(IRWrite2),
        .PCWrite(PCWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
        .instr_done(instr_done2), .trap(trap2)
`ifdef CTRL_PERF_EN
        , .instret(instret2)
`endif
    );

    // Field order: req mw adr irw pcw rw rs sa sb imm alu done trap; D = don't care
    function automatic exp_t O(input int req, input int mw, input int adr, input int irw,
                               input int pcw, input int rw, input int rs, input int sa,
                               input int sb, input int imm, input int alu, input int done,
                               input int trp);
        int          a[13];
        int          w[13];
        logic [20:0] v;
        logic [20:0] m;
        logic [20:0] fm;
        a = '{req, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu, done, trp};
        w = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 4, 1, 1};
        v = '0;
        m = '0;
        for (int i = 0; i < 13; i++) begin
            fm = (21'd1 << w[i]) - 21'd1;
            v  = (v << w[i]) | ((a[i] < 0) ? 21'd0 : (21'(a[i]) & fm));
            m  = (m << w[i]) | ((a[i] < 0) ? 21'd0 : fm);
        end
        return '{v: v, m: m};
    endfunction

    function automatic exp_t fetch_e(input int r);
        return O(1, 0, 0, r, r, 0, 2, 0, 2, D, 0, 0, 0);
    endfunction
    function automatic exp_t exr_e(input int a);
        return O(0, 0, 0, 0, 0, 0, D, 2, 0, D, a, 0, 0);
    endfunction
    function automatic exp_t exi_e(input int a);
        return O(0, 0, 0, 0, 0, 0, D, 2, 1, D, a, 0, 0);
    endfunction
    function automatic exp_t memrd_e(input int r);
        return O(1, 0, 1, 0, 0, 0, D, D, D, D, D, 0, 0);
    endfunction
    function automatic exp_t br_e(input int t);
        return O(0, 0, 0, 0, t, 0, 0, 2, 0, D, 1, 1, 0);
    endfunction

    exp_t E_RST, E_DEC, E_ALUWB, E_MEMADR_L, E_MEMADR_S, E_MEMWB, E_MEMWR;
    exp_t E_JALR, E_JLINK, E_LUI, E_TRAP, E_BRBAD;

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7_5 = f7;
    endtask

    task automatic cyc(input string nm, input logic rdy, input exp_t e);
        ent_t t;
        mem_ready = rdy;
        t.nm = nm;
        t.e = e;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int alu);
        set_instr(o, f3, f7);
        cyc({nm, "_fetch"}, 1'b1, fetch_e(1));
        cyc({nm, "_decode"}, 1'b1, E_DEC);
        cyc({nm, "_exec"}, 1'b1, (o == 7'b0110011) ? exr_e(alu) : exi_e(alu));
        cyc({nm, "_aluwb"}, 1'b1, E_ALUWB);
    endtask

    task automatic jalr_instr();
        set_instr(7'b1100111, 3'b000, 1'b0);
        cyc("jalr_fetch", 1'b1, fetch_e(1));
        cyc("jalr_decode", 1'b1, E_DEC);
        cyc("jalr_jalr", 1'b1, E_JALR);
        cyc("jalr_jlink", 1'b1, E_JLINK);
    endtask

    task automatic lui_instr();
        set_instr(7'b0110111, 3'b000, 1'b0);
        cyc("lui_fetch", 1'b1, fetch_e(1));
        cyc("lui_decode", 1'b1, E_DEC);
        cyc("lui_lui", 1'b1, E_LUI);
        cyc("lui_aluwb", 1'b1, E_ALUWB);
    endtask

    // Monitor: the DUT presents a control vector every cycle the bench has queued one
    always @(negedge clk) begin
        logic [20:0] act;
        ent_t        t;
        if (q.size() > 0) begin
            t = q.pop_front();
            act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, trap};
            checks++;
            if (((act ^ t.e.v) & t.e.m) != 21'd0) begin
                errors++;
                $display("FAIL %s: got %b want %b (care %b)", t.nm, act, t.e.v, t.e.m);
            end
        end
    end

    // Timeout instance: mem_ready stuck low in FETCH, trap expected on the 5th cycle
    initial begin
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (trap2 !== (c == 5)) begin
                errors++;
                $display("FAIL timeout_trap_c%0d: got %b want %b", c, trap2, (c == 5));
            end
            checks++;
            if (mem_req2 !== (c != 5)) begin
                errors++;
                $display("FAIL timeout_memreq_c%0d: got %b want %b", c, mem_req2, (c != 5));
            end
        end
        t2_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        E_RST      = O(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        E_DEC      = O(0, 0, 0, 0, 0, 0, D, 1, 1, 2, 0, 0, 0);
        E_ALUWB    = O(0, 0, 0, 0, 0, 1, 0, D, D, D, D, 1, 0);
        E_MEMADR_L = O(0, 0, 0, 0, 0, 0, D, 2, 1, 0, 0, 0, 0);
        E_MEMADR_S = O(0, 0, 0, 0, 0, 0, D, 2, 1, 1, 0, 0, 0);
        E_MEMWB    = O(0, 0, 0, 0, 0, 1, 1, D, D, D, D, 1, 0);
        E_MEMWR    = O(1, 1, 1, 0, 0, 0, D, D, D, D, D, 1, 0);
        E_JALR     = O(0, 0, 0, 0, 1, 0, 2, 2, 1, 0, 0, 0, 0);
        E_JLINK    = O(0, 0, 0, 0, 0, 1, 2, 1, 2, D, D, 1, 0);
        E_LUI      = O(0, 0, 0, 0, 0, 0, D, 3, 1, 4, 0, 0, 0);
        E_TRAP     = O(0, 0, 0, 0, 0, 0, D, D, D, D, D, 0, 1);
        E_BRBAD    = O(0, 0, 0, 0, 0, 0, D, D, D, D, D, 0, 0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("reset0", 1'b1, E_RST);
        cyc("reset1", 1'b1, E_RST);
        rst = 1'b0;

        alu_instr("add", 7'b0110011, 3'b000, 1'b0, 0);
        alu_instr("sub", 7'b0110011, 3'b000, 1'b1, 1);
        alu_instr("srai", 7'b0010011, 3'b101, 1'b1, 9);
        alu_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 0);
        alu_instr("sltu", 7'b0110011, 3'b011, 1'b0, 6);

        set_instr(7'b0000011, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", 1'b0, fetch_e(0));
        cyc("lw_fetch", 1'b1, fetch_e(1));
        cyc("lw_decode", 1'b1, E_DEC);
        cyc("lw_memadr", 1'b1, E_MEMADR_L);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, memrd_e(0));
        cyc("lw_memrd", 1'b1, memrd_e(1));
        cyc("lw_memwb", 1'b1, E_MEMWB);

        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", 1'b1, fetch_e(1));
        cyc("sw_decode", 1'b1, E_DEC);
        cyc("sw_memadr", 1'b1, E_MEMADR_S);
        cyc("sw_memwr", 1'b1, E_MEMWR);

        Zero = 1'b0; LT = 1'b0; LTU = 1'b1;
        set_instr(7'b1100011, 3'b110, 1'b0);
        cyc("bltu_fetch", 1'b1, fetch_e(1));
        cyc("bltu_decode", 1'b1, E_DEC);
        cyc("bltu_branch", 1'b1, br_e(1));
        set_instr(7'b1100011, 3'b111, 1'b0);
        cyc("bgeu_fetch", 1'b1, fetch_e(1));
        cyc("bgeu_decode", 1'b1, E_DEC);
        cyc("bgeu_branch", 1'b1, br_e(0));
        Zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc("beq_fetch", 1'b1, fetch_e(1));
        cyc("beq_decode", 1'b1, E_DEC);
        cyc("beq_branch", 1'b1, br_e(1));

        jalr_instr();

        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc("ill_fetch", 1'b1, fetch_e(1));
        cyc("ill_decode", 1'b1, E_DEC);
        for (int i = 0; i < 10; i++) cyc("ill_trap", 1'b1, E_TRAP);
        rst = 1'b1;
        cyc("ill_reset", 1'b1, E_RST);
        rst = 1'b0;
        cyc("ill_after_rst", 1'b0, fetch_e(0));
        cyc("ill_after_rst2", 1'b1, fetch_e(1));

        set_instr(7'b1100011, 3'b010, 1'b0);
        cyc("brbad_decode", 1'b1, E_DEC);
        cyc("brbad_branch", 1'b1, E_BRBAD);
        cyc("brbad_trap", 1'b1, E_TRAP);
        rst = 1'b1;
        cyc("brbad_reset", 1'b1, E_RST);
        rst = 1'b0;

        alu_instr("add2", 7'b0110011, 3'b000, 1'b0, 0);
        lui_instr();
        jalr_instr();
`ifdef CTRL_PERF_EN
        checks++;
        if (instret !== 32'd3) begin
            errors++;
            $display("FAIL instret: got %0d want 3", instret);
        end
`endif

        for (int i = 0; i < 20 && !t2_done; i++) @(posedge clk);
        if (!t2_done) begin
            errors++;
            $display("FAIL timeout_instance: check process did not complete");
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
